// File: rtl/flop_pkg.sv
// flop_pkg: shared field widths, constants, FSM state encoding and field helpers
// for the 13-bit floating-point format {sign, exponent[3:0] (bias 7), fraction[7:0]}.
package flop_pkg;

    localparam int SIGN_BIT = 12;
    localparam int EXP_W    = 4;
    localparam int MANT_W   = 8;
    localparam int BIAS     = 7;
    localparam int WORK_W   = 12;  // hidden bit, 8 fraction bits, guard, round, sticky

    localparam logic [12:0] MAX_FINITE = 13'h0FFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4,
        ST_DONE  = 3'd5
    } flop_state_e;

    function automatic logic get_sign(input logic [SIGN_BIT:0] v);
        return v[SIGN_BIT];
    endfunction

    function automatic logic [EXP_W-1:0] get_exp(input logic [SIGN_BIT:0] v);
        return v[MANT_W +: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] get_frac(input logic [SIGN_BIT:0] v);
        return v[MANT_W-1:0];
    endfunction

    // Working mantissa with hidden bit and three clear low bits; exponent 0 means zero.
    function automatic logic [WORK_W-1:0] work_mant(input logic [SIGN_BIT:0] v);
        if (get_exp(v) == 4'd0) begin
            return 12'h000;
        end else begin
            return {1'b1, get_frac(v), 3'b000};
        end
    endfunction

    function automatic logic [SIGN_BIT:0] pack_fp(input logic s,
                                                  input logic [EXP_W-1:0] e,
                                                  input logic [MANT_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/flop_round.sv
// flop_round: combinational rounder for a normalized 12-bit working mantissa.
// FLOP_SEQ_RNE_EN defined: round to nearest, ties to even. Undefined: truncate.
// Exponents above 15 saturate to the largest finite magnitude with ovf set.
module flop_round
    import flop_pkg::*;
(
    input  logic        sign,
    input  logic [4:0]  exponent,
    input  logic [11:0] mant,
    output logic [12:0] result,
    output logic        ovf
);

    logic       inc_s;
    logic [9:0] rounded_s;
    logic [4:0] exp_adj_s;
    logic [7:0] frac_s;

`ifdef FLOP_SEQ_RNE_EN
    // Nearest-even: bump when guard is set and either round, sticky or the lsb is set.
    always_comb begin
        inc_s = mant[2] & (mant[1] | mant[0] | mant[3]);
    end
`else
    logic unused_grs_s;

    // Truncation: guard, round and sticky are discarded.
    always_comb begin
        inc_s        = 1'b0;
        unused_grs_s = ^mant[2:0];
    end
`endif

    // Apply the increment, renormalise a mantissa carry and saturate exponent overflow.
    always_comb begin
        rounded_s = {1'b0, mant[11:3]} + {9'd0, inc_s};
        exp_adj_s = exponent + {4'd0, rounded_s[9]};
        if (rounded_s[9]) begin
            frac_s = rounded_s[8:1];
        end else begin
            frac_s = rounded_s[7:0];
        end
        if (exp_adj_s > 5'd15) begin
            result = {sign, MAX_FINITE[11:0]};
            ovf    = 1'b1;
        end else begin
            result = pack_fp(sign, exp_adj_s[3:0], frac_s);
            ovf    = 1'b0;
        end
    end

endmodule

// File: rtl/flop_seq.sv
// flop_seq: multi-cycle add/subtract unit for 13-bit floating point.
// Sequence: IDLE -> ALIGN -> ADD -> NORM (one shift per cycle) -> ROUND -> DONE.
// Optional macro FLOP_SEQ_RNE_EN (consumed by flop_round) selects round-to-nearest-even;
// the default build truncates with identical latency.
module flop_seq
    import flop_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:0] a,
    input  logic [12:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        busy
);

    flop_state_e state_r;
    flop_state_e state_nxt_s;

    logic [12:0] op_a_r;
    logic [12:0] op_b_r;
    logic        sign_r;
    logic        sign_b_r;
    logic [4:0]  exp_r;       // one spare bit so a carry out of exponent 15 is visible to ROUND
    logic [11:0] mant_a_r;
    logic [11:0] mant_b_r;
    logic [12:0] sum_r;

    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;
    logic [12:0] result_r;
    logic        ovf_r;
    logic        unf_r;

    logic        a_ge_b_s;
    logic [12:0] big_s;
    logic [12:0] small_s;
    logic [11:0] big_mant_s;
    logic [11:0] small_mant_s;
    logic [3:0]  diff_s;
    logic [11:0] lost_mask_s;
    logic [11:0] shifted_s;
    logic [12:0] add_sum_s;
    logic        add_zero_s;
    logic        norm_unf_s;
    logic [12:0] rnd_result_s;
    logic        rnd_ovf_s;

    // Order operands by magnitude and align the smaller one, folding lost bits into sticky.
    always_comb begin
        a_ge_b_s = (get_exp(op_a_r) > get_exp(op_b_r)) ||
                   ((get_exp(op_a_r) == get_exp(op_b_r)) &&
                    (work_mant(op_a_r) >= work_mant(op_b_r)));
        if (a_ge_b_s) begin
            big_s   = op_a_r;
            small_s = op_b_r;
        end else begin
            big_s   = op_b_r;
            small_s = op_a_r;
        end
        big_mant_s   = work_mant(big_s);
        small_mant_s = work_mant(small_s);
        diff_s       = get_exp(big_s) - get_exp(small_s);
        lost_mask_s  = (12'd1 << diff_s) - 12'd1;
        if (diff_s >= 4'd12) begin
            shifted_s = {11'd0, |small_mant_s};
        end else begin
            shifted_s = (small_mant_s >> diff_s) | {11'd0, |(small_mant_s & lost_mask_s)};
        end
    end

    // Effective add or subtract of the aligned mantissas; |A| >= |B| keeps A-B non-negative.
    always_comb begin
        if (sign_r == sign_b_r) begin
            add_sum_s = {1'b0, mant_a_r} + {1'b0, mant_b_r};
        end else begin
            add_sum_s = {1'b0, mant_a_r} - {1'b0, mant_b_r};
        end
        add_zero_s = (add_sum_s == 13'd0);
        norm_unf_s = (state_r == ST_NORM) && !sum_r[12] && !sum_r[11] && (exp_r == 5'd1);
    end

    // Next-state selection for the operation sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_nxt_s = ST_ALIGN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALIGN: state_nxt_s = ST_ADD;
            ST_ADD: begin
                if (add_zero_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_NORM;
                end
            end
            ST_NORM: begin
                if (sum_r[12] || sum_r[11]) begin
                    state_nxt_s = ST_ROUND;
                end else if (norm_unf_s) begin
                    state_nxt_s = ST_DONE;
                end else if (sum_r[10]) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_NORM;
                end
            end
            ST_ROUND: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and handshake/status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand latch, alignment, addition and normalization datapath.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_a_r   <= 13'd0;
            op_b_r   <= 13'd0;
            sign_r   <= 1'b0;
            sign_b_r <= 1'b0;
            exp_r    <= 5'd0;
            mant_a_r <= 12'd0;
            mant_b_r <= 12'd0;
            sum_r    <= 13'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        op_a_r <= a;
                        op_b_r <= {b[12] ^ sub, b[11:0]};
                    end
                end
                ST_ALIGN: begin
                    sign_r   <= get_sign(big_s);
                    sign_b_r <= get_sign(small_s);
                    exp_r    <= {1'b0, get_exp(big_s)};
                    mant_a_r <= big_mant_s;
                    mant_b_r <= shifted_s;
                end
                ST_ADD: begin
                    sum_r <= add_sum_s;
                end
                ST_NORM: begin
                    if (sum_r[12]) begin
                        sum_r <= {1'b0, sum_r[12:2], sum_r[1] | sum_r[0]};
                        exp_r <= exp_r + 5'd1;
                    end else if (!sum_r[11] && !norm_unf_s) begin
                        sum_r <= {sum_r[11:0], 1'b0};
                        exp_r <= exp_r - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result and flags are captured on entry to DONE and held until the next operation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_r <= 13'd0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else if ((state_r == ST_ADD) && add_zero_s) begin
            result_r <= 13'd0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else if (norm_unf_s) begin
            result_r <= {sign_r, 12'h000};
            ovf_r    <= 1'b0;
            unf_r    <= 1'b1;
        end else if (state_r == ST_ROUND) begin
            result_r <= rnd_result_s;
            ovf_r    <= rnd_ovf_s;
            unf_r    <= 1'b0;
        end
    end

    flop_round u_round (
        .sign     (sign_r),
        .exponent (exp_r),
        .mant     (sum_r[11:0]),
        .result   (rnd_result_s),
        .ovf      (rnd_ovf_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign ovf       = ovf_r;
    assign unf       = unf_r;

endmodule

// File: tb/tb_flop_seq.sv
// Directed and randomized bench for flop_seq against an exact-arithmetic reference.
module tb_flop_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] a;
    logic [12:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] result;
    logic        ovf;
    logic        unf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flop_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Real value of an encoding in units of 2^-14 (the lsb weight at exponent 1).
    function automatic longint val_of(input logic [12:0] x);
        longint m;
        if (x[11:8] == 4'd0) return 64'sd0;
        m = 64'sd256 + longint'(x[7:0]);
        m = m << (x[11:8] - 4'd1);
        return x[12] ? -m : m;
    endfunction

    // Exact sum, then normalize/round by value; returns {ovf, unf, result}.
    function automatic logic [14:0] ref_op(input logic [12:0] ra, input logic [12:0] rb,
                                           input logic rsub);
        longint s, m, q;
        int     p, e;
        logic   sg;
`ifdef FLOP_SEQ_RNE_EN
        longint rem, half;
`endif
        s = val_of(ra) + (rsub ? -val_of(rb) : val_of(rb));
        if (s == 64'sd0) return 15'h0000;
        sg = (s < 64'sd0);
        m  = sg ? -s : s;
        p  = 0;
        while ((m >> (p + 1)) != 64'sd0) p++;
        e = p - 7;
        if (e <= 0) return {1'b0, 1'b1, sg, 12'h000};
        q = m >> (e - 1);
`ifdef FLOP_SEQ_RNE_EN
        rem = m - (q << (e - 1));
        if (e >= 2) begin
            half = 64'sd1 << (e - 2);
            if ((rem > half) || ((rem == half) && q[0])) q++;
        end
`endif
        if (q == 64'sd512) begin
            q = 64'sd256;
            e++;
        end
        if (e >= 16) return {1'b1, 1'b0, sg, 12'hFFF};
        return {1'b0, 1'b0, sg, 4'(e), 8'(q)};
    endfunction

    // One complete transaction; exp_lat < 0 skips the latency check, hold = stall cycles.
    task automatic run_op(input string tag, input logic [12:0] ta, input logic [12:0] tb,
                          input logic tsub, input logic [12:0] exp_res, input logic exp_ovf,
                          input logic exp_unf, input int exp_lat, input int hold);
        int lat;
        chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        chk({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
        a = ~ta; b = ~tb; sub = ~tsub;   // must be ignored while busy
        lat = 0;
        while ((out_valid !== 1'b1) && (lat < 40)) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
        if (exp_lat >= 0) chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/result"}, 32'(result), 32'(exp_res));
        chk({tag, "/ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, "/unf"}, 32'(unf), 32'(exp_unf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "/hold_result"}, 32'(result), 32'(exp_res));
            chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "/back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [12:0] ra, rb;
        logic        rs;
        logic [14:0] r;
        int          stray;
        logic [12:0] rnd_exp;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 13'd0; b = 13'd0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/result", 32'(result), 32'd0);
        chk("rst/ovf", 32'(ovf), 32'd0);
        chk("rst/unf", 32'(unf), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("1p1",      13'h0700, 13'h0700, 1'b0, 13'h0800, 1'b0, 1'b0, 4, 0);
        run_op("256p1",    13'h0F00, 13'h0700, 1'b0, 13'h0F01, 1'b0, 1'b0, 4, 0);
        run_op("1.5p1.5",  13'h0780, 13'h0780, 1'b0, 13'h0880, 1'b0, 1'b0, 4, 5);
        run_op("cancel",   13'h0F01, 13'h0F00, 1'b1, 13'h0700, 1'b0, 1'b0, 11, 0);
        run_op("exactzero",13'h0700, 13'h0700, 1'b1, 13'h0000, 1'b0, 1'b0, 2, 0);
        run_op("underflow",13'h0701, 13'h0700, 1'b1, 13'h0000, 1'b0, 1'b1, -1, 0);
        run_op("ovf_pos",  13'h0FFF, 13'h0FFF, 1'b0, 13'h0FFF, 1'b1, 1'b0, 4, 0);
        run_op("ovf_neg",  13'h1FFF, 13'h1FFF, 1'b0, 13'h1FFF, 1'b1, 1'b0, 4, 0);
`ifdef FLOP_SEQ_RNE_EN
        rnd_exp = 13'h0F02;
`else
        rnd_exp = 13'h0F01;
`endif
        run_op("rounding", 13'h0F01, 13'h0600, 1'b0, rnd_exp, 1'b0, 1'b0, 4, 0);

        // Reset pulse in the middle of a long normalization.
        a = 13'h0F01; b = 13'h0F00; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst/busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("midrst/in_ready", 32'(in_ready), 32'd1);
        chk("midrst/busy", 32'(busy), 32'd0);
        chk("midrst/out_valid", 32'(out_valid), 32'd0);
        chk("midrst/result", 32'(result), 32'd0);
        stray = 0;
        out_ready = 1'b1;   // no effect outside DONE
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
        end
        out_ready = 1'b0;
        chk("midrst/no_partial", 32'(stray), 32'd0);
        run_op("after_rst", 13'h0700, 13'h0700, 1'b0, 13'h0800, 1'b0, 1'b0, 4, 0);

        // Randomized operations against the exact-value reference.
        for (int i = 0; i < 150; i++) begin
            ra = 13'($urandom);
            rb = 13'($urandom);
            rs = 1'($urandom);
            if ((i % 3) == 0) rb = {rb[12], ra[11:8], rb[7:0]};
            if ((i % 11) == 0) rb[11:8] = 4'd0;
            r = ref_op(ra, rb, rs);
            run_op($sformatf("rand%0d", i), ra, rb, rs, r[12:0], r[14], r[13], -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
